// File: rtl/processador_n.sv
// processador_n: accumulator CPU with a five-state multicycle control path, a synchronous
// program ROM port, a synchronous data RAM port and simple switch/display style I/O.
module processador_n #(
    parameter int DW   = 8,
    parameter int NREG = 4,
    parameter int PAW  = 8,
    parameter int DAW  = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    output logic [PAW-1:0] prog_addr,
    input  logic [15:0]    prog_data,
    output logic [DAW-1:0] mem_addr,
    output logic [DW-1:0]  mem_wdata,
    output logic           mem_we,
    input  logic [DW-1:0]  mem_rdata,
    input  logic [DW-1:0]  stdin,
    output logic [DW-1:0]  stdout,
    output logic [DW-1:0]  acc_out,
    output logic [PAW-1:0] pc_out,
    output logic           flag_c,
    output logic           flag_z,
    output logic           halted
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM_R  = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_AND   = 4'd3,
        OP_OR    = 4'd4,
        OP_NOT   = 4'd5,
        OP_XOR   = 4'd6,
        OP_CLEAR = 4'd7,
        OP_MOVE  = 4'd8,
        OP_LOAD  = 4'd9,
        OP_STORE = 4'd10,
        OP_PRINT = 4'd11,
        OP_JMP   = 4'd12,
        OP_JZ    = 4'd13,
        OP_IN    = 4'd14,
        OP_HALT  = 4'd15
    } opcode_t;

    // Widened add/subtract: the top bit is the carry-out or the unsigned borrow.
    function automatic logic [DW:0] add_wide(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [DW:0] sub_wide(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    state_t         state_r;
    state_t         state_nxt_s;
    logic [PAW-1:0] pc_r;
    logic [PAW-1:0] pc_nxt_s;
    logic [PAW-1:0] jmp_tgt_s;
    logic [DW-1:0]  acc_r;
    logic [DW-1:0]  regs_r [NREG];
    logic [15:0]    ir_r;
    logic [DW-1:0]  stdout_r;
    logic           flag_c_r;
    logic           flag_z_r;
    logic           halted_r;

    opcode_t        op_s;
    logic [3:0]     ridx_s;
    logic [DW-1:0]  imm_s;
    logic [DW-1:0]  reg_rd_s;
    logic [DW-1:0]  alu_src_s;
    logic [DW-1:0]  data_src_s;
    logic [DW:0]    alu_res_s;
    logic           is_alu_s;
    logic           exec_s;
    logic           dest_we_s;
    logic [DW-1:0]  dest_val_s;

    assign op_s      = opcode_t'(ir_r[15:12]);
    assign ridx_s    = ir_r[11:8];
    assign imm_s     = DW'(ir_r[7:0]);
    assign jmp_tgt_s = PAW'(ir_r[7:0]);
    assign exec_s    = (state_r == ST_EXEC);
    assign is_alu_s  = (op_s inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_XOR});

    // Register file read port; indices above NREG read as zero.
    always_comb begin
        reg_rd_s = {DW{1'b0}};
        for (int i = 0; i < NREG; i++) begin
            reg_rd_s = (ridx_s == 4'(i + 1)) ? regs_r[i] : reg_rd_s;
        end
    end

    // Index 0 means the immediate for ALU sources, but the accumulator for STORE/PRINT.
    assign alu_src_s  = (ridx_s == 4'd0) ? imm_s : reg_rd_s;
    assign data_src_s = (ridx_s == 4'd0) ? acc_r : reg_rd_s;

    // ALU result with carry/borrow in the extra top bit.
    always_comb begin
        alu_res_s = {(DW + 1){1'b0}};
        case (op_s)
            OP_ADD:  alu_res_s = add_wide(acc_r, alu_src_s);
            OP_SUB:  alu_res_s = sub_wide(acc_r, alu_src_s);
            OP_AND:  alu_res_s = {1'b0, acc_r & alu_src_s};
            OP_OR:   alu_res_s = {1'b0, acc_r | alu_src_s};
            OP_NOT:  alu_res_s = {1'b0, ~alu_src_s};
            OP_XOR:  alu_res_s = {1'b0, acc_r ^ alu_src_s};
            default: alu_res_s = {(DW + 1){1'b0}};
        endcase
    end

    // Destination write selection for CLEAR/MOVE/IN in EXEC and for LOAD completion.
    always_comb begin
        dest_we_s  = 1'b0;
        dest_val_s = {DW{1'b0}};
        if (exec_s) begin
            case (op_s)
                OP_CLEAR: begin
                    dest_we_s  = 1'b1;
                    dest_val_s = {DW{1'b0}};
                end
                OP_MOVE: begin
                    dest_we_s  = 1'b1;
                    dest_val_s = imm_s;
                end
                OP_IN: begin
                    dest_we_s  = 1'b1;
                    dest_val_s = stdin;
                end
                default: begin
                    dest_we_s  = 1'b0;
                    dest_val_s = {DW{1'b0}};
                end
            endcase
        end else if (state_r == ST_MEM_R) begin
            dest_we_s  = 1'b1;
            dest_val_s = mem_rdata;
        end else begin
            dest_we_s  = 1'b0;
            dest_val_s = {DW{1'b0}};
        end
    end

    // Program counter successor for the instruction in EXEC.
    always_comb begin
        pc_nxt_s = pc_r + PAW'(1'b1);
        case (op_s)
            OP_JMP:  pc_nxt_s = jmp_tgt_s;
            OP_JZ:   pc_nxt_s = flag_z_r ? jmp_tgt_s : (pc_r + PAW'(1'b1));
            OP_HALT: pc_nxt_s = pc_r;
            default: pc_nxt_s = pc_r + PAW'(1'b1);
        endcase
    end

    // Control FSM next state; en only gates the exit from FETCH.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_FETCH:  state_nxt_s = en ? ST_DECODE : ST_FETCH;
            ST_DECODE: state_nxt_s = ST_EXEC;
            ST_EXEC: begin
                if (op_s == OP_LOAD) begin
                    state_nxt_s = ST_MEM_R;
                end else if (op_s == OP_HALT) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_MEM_R:  state_nxt_s = ST_FETCH;
            ST_HALT:   state_nxt_s = ST_HALT;
            default:   state_nxt_s = ST_FETCH;
        endcase
    end

    // Control FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Instruction register and program counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_r <= 16'h0000;
            pc_r <= {PAW{1'b0}};
        end else begin
            if (state_r == ST_DECODE) begin
                ir_r <= prog_data;
            end
            if (exec_s) begin
                pc_r <= pc_nxt_s;
            end
        end
    end

    // Accumulator and flags; only ALU opcodes touch the flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r    <= {DW{1'b0}};
            flag_c_r <= 1'b0;
            flag_z_r <= 1'b0;
        end else begin
            if (exec_s && is_alu_s) begin
                acc_r    <= alu_res_s[DW-1:0];
                flag_c_r <= alu_res_s[DW];
                flag_z_r <= (alu_res_s[DW-1:0] == {DW{1'b0}});
            end else if (dest_we_s && (ridx_s == 4'd0)) begin
                acc_r <= dest_val_s;
            end
        end
    end

    // General registers; writes to indices above NREG fall through untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {DW{1'b0}};
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (dest_we_s && (ridx_s == 4'(i + 1))) begin
                    regs_r[i] <= dest_val_s;
                end
            end
        end
    end

    // Display latch and halt indicator.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stdout_r <= {DW{1'b0}};
            halted_r <= 1'b0;
        end else begin
            if (exec_s && (op_s == OP_PRINT)) begin
                stdout_r <= data_src_s;
            end
            if (exec_s && (op_s == OP_HALT)) begin
                halted_r <= 1'b1;
            end
        end
    end

    // Data RAM port, decoded from the state so reset clears it immediately.
    always_comb begin
        mem_addr  = {DAW{1'b0}};
        mem_wdata = {DW{1'b0}};
        mem_we    = 1'b0;
        if (exec_s && (op_s == OP_STORE)) begin
            mem_addr  = DAW'(ir_r[7:0]);
            mem_wdata = data_src_s;
            mem_we    = 1'b1;
        end else if ((exec_s || (state_r == ST_MEM_R)) && (op_s == OP_LOAD)) begin
            mem_addr  = DAW'(ir_r[7:0]);
            mem_wdata = {DW{1'b0}};
            mem_we    = 1'b0;
        end else begin
            mem_addr  = {DAW{1'b0}};
            mem_wdata = {DW{1'b0}};
            mem_we    = 1'b0;
        end
    end

    assign prog_addr = pc_r;
    assign pc_out    = pc_r;
    assign acc_out   = acc_r;
    assign stdout    = stdout_r;
    assign flag_c    = flag_c_r;
    assign flag_z    = flag_z_r;
    assign halted    = halted_r;

endmodule

// File: tb/tb_processador_n.sv
// Bench for processador_n: directed programs plus a random program, each instruction
// checked against an instruction-level model of the ISA kept in plain integers.
module tb_processador_n;
    localparam int DW   = 8;
    localparam int NREG = 4;
    localparam int PAW  = 8;
    localparam int DAW  = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           en  = 1'b0;
    logic [PAW-1:0] prog_addr;
    logic [15:0]    prog_data;
    logic [DAW-1:0] mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic           mem_we;
    logic [DW-1:0]  mem_rdata;
    logic [DW-1:0]  stdin = 8'h00;
    logic [DW-1:0]  stdout;
    logic [DW-1:0]  acc_out;
    logic [PAW-1:0] pc_out;
    logic           flag_c;
    logic           flag_z;
    logic           halted;

    processador_n #(.DW(DW), .NREG(NREG), .PAW(PAW), .DAW(DAW)) dut (
        .clk(clk), .rst(rst), .en(en),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .stdin(stdin), .stdout(stdout), .acc_out(acc_out), .pc_out(pc_out),
        .flag_c(flag_c), .flag_z(flag_z), .halted(halted)
    );

    always #5 clk = ~clk;

    // Program ROM with one cycle of read latency.
    logic [15:0] rom [256];
    logic [15:0] rom_q = 16'h0000;
    always @(posedge clk) rom_q <= rom[prog_addr];
    assign prog_data = rom_q;

    // Data RAM with one cycle of read latency, filled with a known pattern on the first edge.
    logic [7:0] ram [256];
    logic [7:0] ram_q = 8'h00;
    logic       ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i * 37 + 11);
            ram_ready <= 1'b1;
        end else if (mem_we === 1'b1) begin
            ram[mem_addr] <= mem_wdata;
        end
        ram_q <= ram[mem_addr];
    end
    assign mem_rdata = ram_q;

    // Write-pulse monitor.
    int         we_cnt  = 0;
    logic [7:0] st_addr = 8'h00;
    logic [7:0] st_data = 8'h00;
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            we_cnt  <= we_cnt + 1;
            st_addr <= mem_addr;
            st_data <= mem_wdata;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ISA-level reference state.
    int m_acc, m_pc, m_c, m_z, m_out, m_halt;
    int m_r [NREG];
    int m_mem [256];
    int m_lat, m_store, m_st_a, m_st_d;

    task automatic model_reset();
        m_acc = 0; m_pc = 0; m_c = 0; m_z = 0; m_out = 0; m_halt = 0;
        for (int i = 0; i < NREG; i++) m_r[i] = 0;
    endtask

    function automatic int rd_reg(input int r);
        return (r >= 1 && r <= NREG) ? m_r[r - 1] : 0;
    endfunction

    task automatic set_dest(input int r, input int v);
        if (r == 0) m_acc = v;
        else if (r <= NREG) m_r[r - 1] = v;
    endtask

    task automatic model_exec(input int sin);
        int ins, op, r, imm, src, res, nxt;
        ins = int'(rom[m_pc]);
        op  = (ins >> 12) & 15;
        r   = (ins >> 8) & 15;
        imm = ins & 255;
        src = (r == 0) ? imm : rd_reg(r);
        nxt = (m_pc + 1) % 256;
        m_lat = 3;
        m_store = 0;
        case (op)
            1: begin res = m_acc + src; m_c = (res > 255) ? 1 : 0; m_acc = res % 256; m_z = (m_acc == 0) ? 1 : 0; end
            2: begin m_c = (m_acc < src) ? 1 : 0; m_acc = (m_acc - src) & 255; m_z = (m_acc == 0) ? 1 : 0; end
            3: begin m_acc = m_acc & src; m_c = 0; m_z = (m_acc == 0) ? 1 : 0; end
            4: begin m_acc = m_acc | src; m_c = 0; m_z = (m_acc == 0) ? 1 : 0; end
            5: begin m_acc = (~src) & 255; m_c = 0; m_z = (m_acc == 0) ? 1 : 0; end
            6: begin m_acc = m_acc ^ src; m_c = 0; m_z = (m_acc == 0) ? 1 : 0; end
            7: set_dest(r, 0);
            8: set_dest(r, imm);
            9: begin set_dest(r, m_mem[imm]); m_lat = 4; end
            10: begin
                m_store = 1; m_st_a = imm;
                m_st_d = (r == 0) ? m_acc : rd_reg(r);
                m_mem[imm] = m_st_d;
            end
            11: m_out = (r == 0) ? m_acc : rd_reg(r);
            12: nxt = imm;
            13: if (m_z == 1) nxt = imm;
            14: set_dest(r, sin & 255);
            15: begin m_halt = 1; nxt = m_pc; end
            default: ;
        endcase
        m_pc = nxt;
    endtask

    task automatic check_arch(input int w0);
        chk("acc", acc_out, m_acc);
        chk("pc", pc_out, m_pc);
        chk("flag_c", flag_c, m_c);
        chk("flag_z", flag_z, m_z);
        chk("stdout", stdout, m_out);
        chk("halted", halted, m_halt);
        chk("we_pulses", we_cnt - w0, m_store);
        if (m_store != 0) begin
            chk("st_addr", st_addr, m_st_a);
            chk("st_data", st_data, m_st_d);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_acc"}, acc_out, 0);
        chk({tag, "_pc"}, pc_out, 0);
        chk({tag, "_paddr"}, prog_addr, 0);
        chk({tag, "_stdout"}, stdout, 0);
        chk({tag, "_c"}, flag_c, 0);
        chk({tag, "_z"}, flag_z, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_maddr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        #1;
        check_reset("rst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_pc", pc_out, 0);
        chk("idle_paddr", prog_addr, 0);
    endtask

    // One instruction from FETCH to FETCH; optional stalls in FETCH and en noise in flight.
    task automatic run_instr(input bit rand_en, input int sin);
        int w0;
        chk("fetch_addr", prog_addr, m_pc);
        if (rand_en && ($urandom_range(0, 3) == 0)) begin
            en = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            chk("stall_pc", pc_out, m_pc);
        end
        stdin = 8'(sin);
        en = 1'b1;
        w0 = we_cnt;
        model_exec(sin);
        for (int c = 0; c < m_lat; c++) begin
            @(negedge clk);
            if (rand_en && (c < m_lat - 1)) en = 1'($urandom_range(0, 1));
        end
        check_arch(w0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [15:0] w;
        int w_start;
        for (int i = 0; i < 256; i++) m_mem[i] = (i * 37 + 11) % 256;

        // ADD with carry out
        clear_rom();
        rom[0] = 16'h80F0; rom[1] = 16'h1020;
        do_reset();
        run_instr(1'b0, 0); run_instr(1'b0, 0);
        chk("add_acc", acc_out, 8'h10);
        chk("add_c", flag_c, 1'b1);
        chk("add_z", flag_z, 1'b0);

        // SUB to zero then taken JZ
        clear_rom();
        rom[0] = 16'h8005; rom[1] = 16'h2005; rom[2] = 16'hD010;
        do_reset();
        for (int i = 0; i < 3; i++) run_instr(1'b0, 0);
        chk("jz_acc", acc_out, 8'h00);
        chk("jz_z", flag_z, 1'b1);
        chk("jz_pc", pc_out, 8'h10);

        // STORE / LOAD round trip and PRINT
        clear_rom();
        rom[0] = 16'h813C; rom[1] = 16'hA107; rom[2] = 16'h7000; rom[3] = 16'h9007; rom[4] = 16'hB000;
        do_reset();
        w_start = we_cnt;
        for (int i = 0; i < 5; i++) run_instr(1'b0, 0);
        chk("mem_pulses", we_cnt - w_start, 1);
        chk("mem_addr7", st_addr, 8'h07);
        chk("mem_data", st_data, 8'h3C);
        chk("print_3c", stdout, 8'h3C);

        // IN / XOR, then reset in the middle of a LOAD
        clear_rom();
        rom[0] = 16'hE200; rom[1] = 16'h80FF; rom[2] = 16'h6200; rom[3] = 16'h9233;
        do_reset();
        run_instr(1'b0, 8'hA5); run_instr(1'b0, 0); run_instr(1'b0, 0);
        chk("xor_acc", acc_out, 8'h5A);
        chk("ld_fetch", prog_addr, m_pc);
        en = 1'b1;
        repeat (2) @(negedge clk);
        chk("ld_maddr", mem_addr, 8'h33);
        chk("ld_we", mem_we, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset("midload");
        model_reset();
        clear_rom();
        rom[0] = 16'hB200; rom[1] = 16'hF000;
        @(negedge clk);
        rst = 1'b1;
        run_instr(1'b0, 0);
        chk("dest_after_rst", stdout, 8'h00);
        run_instr(1'b0, 0);

        // PC wrap from 0xFF
        clear_rom();
        rom[0] = 16'hC0FE;
        do_reset();
        for (int i = 0; i < 3; i++) run_instr(1'b0, 0);
        chk("pc_wrap", pc_out, 8'h00);

        // HALT holds regardless of en
        clear_rom();
        rom[0] = 16'h8055; rom[1] = 16'hF000;
        do_reset();
        run_instr(1'b0, 0); run_instr(1'b0, 0);
        chk("halt_flag", halted, 1'b1);
        w_start = we_cnt;
        for (int i = 0; i < 20; i++) begin
            en = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("halt_hold", halted, 1'b1);
            chk("halt_pc", pc_out, m_pc);
            chk("halt_we", mem_we, 1'b0);
        end
        chk("halt_pulses", we_cnt - w_start, 0);
        chk("halt_acc", acc_out, 8'h55);

        // Random program (no HALT) with random stalls and en noise
        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hF) w[15:12] = 4'h0;
            rom[i] = w;
        end
        do_reset();
        for (int i = 0; i < 150; i++) run_instr(1'b1, int'($urandom_range(0, 255)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
